// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one FPU core between NUM_REQ requesters.
// Optional watchdog on the core wait, enabled with `define FPU_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transaction; pick the next requester round-robin from the pointer
// ISSUE  | grant shown, start pulse out (legal op) or error path (illegal op)
// WAIT   | waiting for core_done_i (bounded by the watchdog when enabled)
// FINISH | done shown to the winner until it drops its request

module fpu_req_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ*5-1:0]    op_i,
    input  logic [NUM_REQ*32-1:0]   a_i,
    input  logic [NUM_REQ*32-1:0]   b_i,
    output logic [NUM_REQ-1:0]      grant_o,
    output logic [NUM_REQ-1:0]      done_o,
    output logic [31:0]             result_o,
    output logic                    err_o,
    output logic                    busy_o,
    output logic                    core_start_o,
    output logic [4:0]              core_op_o,
    output logic [31:0]             core_a_o,
    output logic [31:0]             core_b_o,
    input  logic                    core_done_i,
    input  logic [31:0]             core_result_i,
    output logic                    core_abort_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [4:0]         sel_op;

    // First active request at or after the pointer, wrapping around.
    always_comb begin
        int j;
        j         = 0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!sel_valid && req_i[j]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        sel_onehot          = '0;
        sel_onehot[sel_idx] = 1'b1;
        sel_op              = op_i[int'(sel_idx)*5 +: 5];
    end

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] wait_cnt;
    logic            timeout_hit;

    // Combinational so that a core_done_i on the timeout cycle can suppress the abort.
    assign timeout_hit  = (state == WAIT) && !core_done_i &&
                          (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign core_abort_o = timeout_hit;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign core_abort_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt_idx      <= '0;
            grant_o      <= '0;
            done_o       <= '0;
            result_o     <= '0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
            core_start_o <= 1'b0;
            core_op_o    <= '0;
            core_a_o     <= '0;
            core_b_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        gnt_idx      <= sel_idx;
                        core_op_o    <= sel_op;
                        core_a_o     <= a_i[int'(sel_idx)*32 +: 32];
                        core_b_o     <= b_i[int'(sel_idx)*32 +: 32];
                        grant_o      <= sel_onehot;
                        core_start_o <= !sel_op[4];
                        busy_o       <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_start_o <= 1'b0;
                    ptr          <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    if (!core_op_o[4]) begin
                        state <= WAIT;
                    end else begin
                        result_o <= '0;
                        err_o    <= 1'b1;
                        done_o   <= grant_o;
                        state    <= FINISH;
                    end
                end
                WAIT: begin
                    if (core_done_i) begin
                        result_o <= core_result_i;
                        err_o    <= 1'b0;
                        done_o   <= grant_o;
                        state    <= FINISH;
                    end
`ifdef FPU_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        result_o <= 32'h7FC0_0000;
                        err_o    <= 1'b1;
                        done_o   <= grant_o;
                        state    <= FINISH;
                    end
`endif
                end
                FINISH: begin
                    if (!req_i[gnt_idx]) begin
                        done_o  <= '0;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Bench for fpu_req_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level round-robin model.

module tb_fpu_req_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           arst;
    logic [N-1:0]   req_i;
    logic [N*5-1:0] op_i;
    logic [N*32-1:0] a_i, b_i;
    logic [N-1:0]   grant_o, done_o;
    logic [31:0]    result_o;
    logic           err_o, busy_o, core_start_o, core_abort_o;
    logic [4:0]     core_op_o;
    logic [31:0]    core_a_o, core_b_o;
    logic           core_done_i;
    logic [31:0]    core_result_i;

    fpu_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .arst(arst), .req_i(req_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .grant_o(grant_o), .done_o(done_o), .result_o(result_o), .err_o(err_o),
        .busy_o(busy_o), .core_start_o(core_start_o), .core_op_o(core_op_o),
        .core_a_o(core_a_o), .core_b_o(core_b_o), .core_done_i(core_done_i),
        .core_result_i(core_result_i), .core_abort_o(core_abort_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Requester-side state driven onto the DUT inputs
    logic [N-1:0] rq;
    logic [4:0]   rop [N];
    logic [31:0]  ra  [N];
    logic [31:0]  rb  [N];

    task automatic drive();
        req_i = rq;
        for (int r = 0; r < N; r++) begin
            op_i[r*5 +: 5]  = rop[r];
            a_i[r*32 +: 32] = ra[r];
            b_i[r*32 +: 32] = rb[r];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mix(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        return a ^ {b[30:0], b[31]} ^ {27'd0, op} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (p + i) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // Core model: answers rsp_lat cycles after a start pulse
    int          rsp_cnt = 0;
    int          rsp_lat = 3;
    logic        use_fixed = 1'b1;
    logic [31:0] fixed_ret = '0;
    logic [31:0] rsp_val = '0;

    initial begin
        core_done_i   = 1'b0;
        core_result_i = '0;
        forever begin
            @(posedge clk);
            #1;
            core_done_i = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    core_done_i   = 1'b1;
                    core_result_i = rsp_val;
                end
            end
            if (core_start_o) begin
                rsp_cnt = rsp_lat;
                rsp_val = use_fixed ? fixed_ret : mix(core_op_o, core_a_o, core_b_o);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    typedef struct {
        logic [N-1:0] mask;
        logic [4:0]   op;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  ret;
        int           lat;
        int           exp_w;
        logic         exp_err;
        logic [31:0]  exp_res;
    } vec_t;

    vec_t tbl [9];

    task automatic do_reset();
        arst = 1'b1;
        rq   = '0;
        drive();
        step();
        step();
        arst = 1'b0;
        step();
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        logic legal;
        int   n, extra;
        v     = tbl[k];
        legal = (v.op <= 5'd15);
        for (int r = 0; r < N; r++) begin
            if (v.mask[r]) begin
                rop[r] = v.op;
                ra[r]  = v.a;
                rb[r]  = v.b;
            end
        end
        rq        = v.mask;
        use_fixed = 1'b1;
        fixed_ret = v.ret;
        rsp_lat   = v.lat;
        drive();
        step();
        chk($sformatf("vec%0d_grant", k), grant_o, oh(v.exp_w));
        chk($sformatf("vec%0d_start", k), core_start_o, legal);
        chk($sformatf("vec%0d_core_op", k), core_op_o, v.op);
        chk($sformatf("vec%0d_core_a", k), core_a_o, v.a);
        chk($sformatf("vec%0d_core_b", k), core_b_o, v.b);
        n     = 1;
        extra = 0;
        while (done_o == '0 && n < 60) begin
            step();
            n++;
            if (core_start_o) extra++;
        end
        chk($sformatf("vec%0d_done", k), done_o, oh(v.exp_w));
        chk($sformatf("vec%0d_latency", k), n, legal ? v.lat + 2 : 2);
        chk($sformatf("vec%0d_result", k), result_o, v.exp_res);
        chk($sformatf("vec%0d_err", k), err_o, v.exp_err);
        chk($sformatf("vec%0d_extra_start", k), extra, 0);
        rq = '0;
        drive();
        step();
        chk($sformatf("vec%0d_done_clear", k), done_o, '0);
        chk($sformatf("vec%0d_grant_clear", k), grant_o, '0);
        chk($sformatf("vec%0d_busy_clear", k), busy_o, 1'b0);
    endtask

    // Random-phase model state
    int           model_ptr, w, cur_w, fin_left, since_g, busy_run, n_g, cd_at, dn_at;
    logic         rise_g, rise_d, exp_start, legal_cur, in_fin, fin_clear, prev_cd, any_done;
    logic [N-1:0] prev_grant, prev_done, owed, dropped;
    int           order [4];

    initial begin
        // pointer starts at 0 after reset; winners follow from mask and running pointer
        tbl[0] = '{3'b001, 5'd0,  32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5, 0, 1'b0, 32'h4040_0000};
        tbl[1] = '{3'b111, 5'd1,  32'h1234_5678, 32'h0000_0001, 32'h1111_1111, 3, 1, 1'b0, 32'h1111_1111};
        tbl[2] = '{3'b111, 5'd2,  32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h2222_2222, 3, 2, 1'b0, 32'h2222_2222};
        tbl[3] = '{3'b111, 5'd7,  32'h0000_0003, 32'h0000_0004, 32'h3333_3333, 3, 0, 1'b0, 32'h3333_3333};
        tbl[4] = '{3'b010, 5'd20, 32'hAAAA_AAAA, 32'h5555_5555, 32'h4444_4444, 3, 1, 1'b1, 32'h0000_0000};
        tbl[5] = '{3'b001, 5'd3,  32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h5555_5555, 1, 0, 1'b0, 32'h5555_5555};
        tbl[6] = '{3'b101, 5'd31, 32'h1357_9BDF, 32'h2468_ACE0, 32'h6666_6666, 2, 2, 1'b1, 32'h0000_0000};
        tbl[7] = '{3'b110, 5'd15, 32'h7F7F_7F7F, 32'h0101_0101, 32'h7777_7777, 4, 1, 1'b0, 32'h7777_7777};
        tbl[8] = '{3'b011, 5'd16, 32'h0000_FFFF, 32'hFFFF_0000, 32'h8888_8888, 2, 0, 1'b1, 32'h0000_0000};

        for (int r = 0; r < N; r++) begin
            rop[r] = '0;
            ra[r]  = '0;
            rb[r]  = '0;
        end
        rq = '0;
        arst = 1'b1;
        drive();
        step();
        step();
        chk("rst_grant", grant_o, '0);
        chk("rst_done", done_o, '0);
        chk("rst_result", result_o, '0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_start", core_start_o, 1'b0);
        chk("rst_core_op", core_op_o, '0);
        chk("rst_core_a", core_a_o, '0);
        chk("rst_core_b", core_b_o, '0);
        chk("rst_abort", core_abort_o, 1'b0);
        arst = 1'b0;
        step();

        for (int k = 0; k < 9; k++) run_vec(k);

        // Fairness with all three requesting continuously
        do_reset();
        for (int r = 0; r < N; r++) begin
            rop[r] = 5'd2;
            ra[r]  = 32'h100 + r;
            rb[r]  = 32'h200 + r;
        end
        rq        = 3'b111;
        rsp_lat   = 3;
        fixed_ret = 32'hF00D_0000;
        drive();
        n_g        = 0;
        prev_grant = '0;
        for (int c = 0; c < 200 && n_g < 4; c++) begin
            step();
            if (grant_o != '0 && prev_grant == '0) begin
                order[n_g] = rr_pick(grant_o, 0);
                n_g++;
            end
            prev_grant = grant_o;
            for (int r = 0; r < N; r++) rq[r] = !done_o[r];
            drive();
        end
        chk("fair_count", n_g, 4);
        chk("fair_g0", order[0], 0);
        chk("fair_g1", order[1], 1);
        chk("fair_g2", order[2], 2);
        chk("fair_g3", order[3], 0);
        rq = '0;
        drive();
        for (int c = 0; c < 40 && busy_o; c++) step();
        chk("fair_drain", busy_o, 1'b0);

        // Requester 2 drops its request while the core is busy
        rop[2]    = 5'd4;
        ra[2]     = 32'h4242_4242;
        rb[2]     = 32'h0000_0002;
        fixed_ret = 32'hCAFE_F00D;
        rsp_lat   = 6;
        rq        = 3'b100;
        drive();
        step();
        chk("drop_grant", grant_o, 3'b100);
        step();
        rq = '0;
        drive();
        cd_at = -1;
        dn_at = -1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (core_done_i) cd_at = c;
            if (done_o != '0) begin
                dn_at = c;
                break;
            end
        end
        chk("drop_done_after_core", dn_at, cd_at + 1);
        chk("drop_done", done_o, 3'b100);
        chk("drop_result", result_o, 32'hCAFE_F00D);
        step();
        chk("drop_one_cycle", done_o, '0);
        chk("drop_idle", busy_o, 1'b0);

        // Asynchronous reset while waiting on the core
        rop[0]  = 5'd5;
        ra[0]   = 32'h0000_ABCD;
        rb[0]   = 32'h0000_1234;
        rsp_lat = 8;
        rq      = 3'b001;
        drive();
        step();
        step();
        step();
        #1;
        arst = 1'b1;
        #1;
        chk("arst_grant", grant_o, '0);
        chk("arst_done", done_o, '0);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_core_op", core_op_o, '0);
        chk("arst_core_a", core_a_o, '0);
        rq = '0;
        drive();
        step();
        arst     = 1'b0;
        any_done = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (done_o != '0 || busy_o) any_done = 1'b1;
        end
        chk("arst_late_core_done_ignored", any_done, 1'b0);

        // Randomized traffic against the round-robin transaction model
        do_reset();
        use_fixed  = 1'b0;
        model_ptr  = 0;
        cur_w      = 0;
        fin_left   = 0;
        since_g    = 0;
        busy_run   = 0;
        in_fin     = 1'b0;
        fin_clear  = 1'b0;
        legal_cur  = 1'b0;
        owed       = '0;
        prev_grant = '0;
        prev_done  = '0;
        prev_cd    = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            dropped   = '0;
            rise_g    = (grant_o != '0) && (prev_grant == '0);
            rise_d    = (done_o != '0) && (prev_done == '0);
            exp_start = 1'b0;
            if (rise_g) begin
                w = rr_pick(rq, model_ptr);
                if (w < 0) begin
                    chk("rand_spurious_grant", grant_o, '0);
                    w = 0;
                end else begin
                    chk("rand_grant", grant_o, oh(w));
                    chk("rand_core_op", core_op_o, rop[w]);
                    chk("rand_core_a", core_a_o, ra[w]);
                    chk("rand_core_b", core_b_o, rb[w]);
                end
                legal_cur = (rop[w] <= 5'd15);
                exp_start = legal_cur;
                model_ptr = (w + 1) % N;
                cur_w     = w;
                owed[w]   = 1'b1;
                since_g   = 0;
            end else begin
                since_g++;
            end
            chk("rand_start", core_start_o, exp_start);
            chk("rand_busy", busy_o, grant_o != '0);

            if (fin_clear) begin
                chk("rand_done_clear", done_o, '0);
                chk("rand_grant_clear", grant_o, '0);
                fin_clear = 1'b0;
            end else if (in_fin) begin
                chk("rand_finish_hold", done_o, oh(cur_w));
            end else if (rise_d) begin
                chk("rand_done", done_o, oh(cur_w));
                chk("rand_result", result_o, legal_cur ? mix(rop[cur_w], ra[cur_w], rb[cur_w]) : 32'h0);
                chk("rand_err", err_o, !legal_cur);
                if (legal_cur) chk("rand_done_lat", prev_cd, 1'b1);
                else           chk("rand_illegal_lat", since_g, 1);
                in_fin   = 1'b1;
                fin_left = rq[cur_w] ? int'($urandom_range(0, 2)) : 0;
            end

            if (in_fin) begin
                if (fin_left == 0) begin
                    rq[cur_w]      = 1'b0;
                    owed[cur_w]    = 1'b0;
                    dropped[cur_w] = 1'b1;
                    fin_clear      = 1'b1;
                    in_fin         = 1'b0;
                end else begin
                    fin_left--;
                end
            end else if (owed[cur_w] && rq[cur_w] && grant_o != '0 && !rise_g &&
                         $urandom_range(0, 29) == 0) begin
                rq[cur_w] = 1'b0;
            end

            for (int r = 0; r < N; r++) begin
                if (!rq[r] && !owed[r] && !dropped[r] && $urandom_range(0, 3) == 0) begin
                    rq[r]  = 1'b1;
                    rop[r] = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(16, 31))
                                                         : 5'($urandom_range(0, 15));
                    ra[r]  = $urandom;
                    rb[r]  = $urandom;
                end
            end

            busy_run = busy_o ? busy_run + 1 : 0;
            if (busy_run > 40) begin
                chk("rand_watchdog", busy_run, 0);
                break;
            end
            rsp_lat    = $urandom_range(1, 6);
            prev_grant = grant_o;
            prev_done  = done_o;
            prev_cd    = core_done_i;
            drive();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
